rl_pair_dispatcher: RTL

- Producer side of the RL force evaluation pair interface.
- Walks every (reference, neighbor) particle index combination from two position caches and drives the per-filter pair_valid lanes with positions and IDs.
- Honours per-filter back-pressure from the force unit; after the last pair it waits for the force unit buffers to drain, then reports done.
- Sits between the cell position caches and the RL force evaluation unit.

---
 rtl/rl_md_pkg.sv | 32 +++
 rtl/lane_popcount.sv | 26 ++
 rtl/rl_pair_dispatcher.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rl_md_pkg.sv
// ---------------------------------------------------------------------------
// rl_md_pkg
// Shared definitions for the RL pair dispatcher: dispatcher state encoding,
// default widths/lane count, particle ID base, drain delay and a counter
// width helper.
// No ports (package).
// ---------------------------------------------------------------------------
package rl_md_pkg;

   localparam int unsigned RL_DATA_WIDTH        = 32;
   localparam int unsigned RL_PARTICLE_ID_WIDTH = 7;
   localparam int unsigned RL_NUM_FILTER        = 7;
   localparam int unsigned RL_ID_BASE           = 1;
   localparam int unsigned RL_DRAIN_DELAY       = 4;
   localparam int unsigned RL_STATS_WIDTH       = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } disp_state_e;

   // Bits needed to hold values 0..max_val (at least 1).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      int unsigned w;
      w = $clog2(max_val + 1);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/lane_popcount.sv
// ---------------------------------------------------------------------------
// lane_popcount
// Counts the set bits of an N-bit lane vector. Only present when the
// statistics build option RL_PAIR_DISPATCH_STATS_EN is defined.
// Ports:
//   vec_i  in  N    lane vector
//   cnt_o  out CW   number of set bits (combinational)
// ---------------------------------------------------------------------------
`ifdef RL_PAIR_DISPATCH_STATS_EN
module lane_popcount #(
   parameter int unsigned N  = 7,
   parameter int unsigned CW = 3
) (
   input  logic [N-1:0]  vec_i,
   output logic [CW-1:0] cnt_o
);

   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < int'(N); i++) begin
         cnt_o = cnt_o + CW'(vec_i[i]);
      end
   end

endmodule
`endif

// File: rtl/rl_pair_dispatcher.sv
// ---------------------------------------------------------------------------
// rl_pair_dispatcher
// Producer side of the RL force evaluation pair interface. Walks every
// (reference, neighbor) index pair from the two position caches, drives the
// per-filter pair_valid lanes with positions and IDs, honours per-filter
// back-pressure, waits for the force unit to drain and then pulses done.
// Optional build macro: RL_PAIR_DISPATCH_STATS_EN adds the pair_count and
// stall_cycles statistics outputs.
// Ports:
//   clk, rst                clock, asynchronous active-low reset
//   start                   launch pulse (IDLE only)
//   ref_count, nb_count     pass sizes, lane_mask lanes in use
//   ref_rd_addr/ref_rd_x..z reference cache read port (1-cycle latency)
//   nb_rd_addr/nb_rd_x..z   neighbor cache look-ahead read port
//   pair_valid, *_particle_id, ref_x..z, nb_x..z  pair interface
//   back_pressure, all_buffer_empty               force unit status
//   busy, done              status
//   pair_count, stall_cycles (stats build only)
// ---------------------------------------------------------------------------
module rl_pair_dispatcher
   import rl_md_pkg::*;
#(
   parameter int unsigned DATA_WIDTH        = RL_DATA_WIDTH,
   parameter int unsigned PARTICLE_ID_WIDTH = RL_PARTICLE_ID_WIDTH,
   parameter int unsigned NUM_FILTER        = RL_NUM_FILTER,
   parameter int unsigned ID_BASE           = RL_ID_BASE,
   parameter int unsigned DRAIN_DELAY       = RL_DRAIN_DELAY
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [PARTICLE_ID_WIDTH-1:0]     ref_count,
   input  logic [PARTICLE_ID_WIDTH-1:0]     nb_count,
   input  logic [NUM_FILTER-1:0]            lane_mask,
   output logic [PARTICLE_ID_WIDTH-1:0]     ref_rd_addr,
   input  logic [DATA_WIDTH-1:0]            ref_rd_x,
   input  logic [DATA_WIDTH-1:0]            ref_rd_y,
   input  logic [DATA_WIDTH-1:0]            ref_rd_z,
   output logic [PARTICLE_ID_WIDTH-1:0]     nb_rd_addr,
   input  logic [NUM_FILTER*DATA_WIDTH-1:0] nb_rd_x,
   input  logic [NUM_FILTER*DATA_WIDTH-1:0] nb_rd_y,
   input  logic [NUM_FILTER*DATA_WIDTH-1:0] nb_rd_z,
   output logic [NUM_FILTER-1:0]            pair_valid,
   output logic [PARTICLE_ID_WIDTH-1:0]     ref_particle_id,
   output logic [PARTICLE_ID_WIDTH-1:0]     nb_particle_id,
   output logic [DATA_WIDTH-1:0]            ref_x,
   output logic [DATA_WIDTH-1:0]            ref_y,
   output logic [DATA_WIDTH-1:0]            ref_z,
   output logic [NUM_FILTER*DATA_WIDTH-1:0] nb_x,
   output logic [NUM_FILTER*DATA_WIDTH-1:0] nb_y,
   output logic [NUM_FILTER*DATA_WIDTH-1:0] nb_z,
   input  logic [NUM_FILTER-1:0]            back_pressure,
   input  logic                             all_buffer_empty,
   output logic                             busy,
`ifdef RL_PAIR_DISPATCH_STATS_EN
   output logic [RL_STATS_WIDTH-1:0]        pair_count,
   output logic [RL_STATS_WIDTH-1:0]        stall_cycles,
`endif
   output logic                             done
);

   localparam int unsigned PID_W     = PARTICLE_ID_WIDTH;
   localparam int unsigned DRAIN_W   = cnt_width(DRAIN_DELAY);

   disp_state_e         state_q, state_d;
   logic [PID_W-1:0]    ref_idx_q, ref_idx_d;
   logic [PID_W-1:0]    nb_idx_q, nb_idx_d;
   logic [PID_W-1:0]    ref_cnt_q, ref_cnt_d;
   logic [PID_W-1:0]    nb_cnt_q, nb_cnt_d;
   logic [NUM_FILTER-1:0] mask_q, mask_d;
   logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;

   logic                stall_c;
   logic                fire_c;
   logic                nb_last_c;
   logic                ref_last_c;
   logic                drain_min_c;
   logic                launch_c;

   // Back-pressure only matters on lanes that are actually in use.
   assign stall_c     = |(back_pressure & mask_q);
   assign fire_c      = (state_q == ST_STREAM) && !stall_c;
   assign nb_last_c   = (nb_idx_q == (nb_cnt_q - PID_W'(1)));
   assign ref_last_c  = (ref_idx_q == (ref_cnt_q - PID_W'(1)));
   assign drain_min_c = (32'(drain_cnt_q) + 32'd1) >= DRAIN_DELAY;
   assign launch_c    = (state_q == ST_IDLE) && start;

   // Next-state and index sequencing.
   always_comb begin
      state_d     = state_q;
      ref_idx_d   = ref_idx_q;
      nb_idx_d    = nb_idx_q;
      ref_cnt_d   = ref_cnt_q;
      nb_cnt_d    = nb_cnt_q;
      mask_d      = mask_q;
      drain_cnt_d = drain_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               ref_cnt_d = ref_count;
               nb_cnt_d  = nb_count;
               mask_d    = lane_mask;
               ref_idx_d = '0;
               nb_idx_d  = '0;
               if ((ref_count != '0) && (nb_count != '0) && (lane_mask != '0)) begin
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_FETCH: begin
            state_d = ST_STREAM;
         end
         ST_STREAM: begin
            if (!stall_c) begin
               if (!nb_last_c) begin
                  nb_idx_d = nb_idx_q + PID_W'(1);
               end else if (!ref_last_c) begin
                  ref_idx_d = ref_idx_q + PID_W'(1);
                  nb_idx_d  = '0;
                  state_d   = ST_FETCH;
               end else begin
                  drain_cnt_d = '0;
                  state_d     = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // Saturate so a long wait on all_buffer_empty never re-arms the delay.
            if (drain_cnt_q != '1) begin
               drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
            end
            if (drain_min_c && all_buffer_empty) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and index registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         ref_idx_q   <= '0;
         nb_idx_q    <= '0;
         ref_cnt_q   <= '0;
         nb_cnt_q    <= '0;
         mask_q      <= '0;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ref_idx_q   <= ref_idx_d;
         nb_idx_q    <= nb_idx_d;
         ref_cnt_q   <= ref_cnt_d;
         nb_cnt_q    <= nb_cnt_d;
         mask_q      <= mask_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   // Reference address only moves on entry to FETCH; the neighbor address
   // looks one index ahead so the cache output lines up with nb_idx.
   assign ref_rd_addr     = ref_idx_q;
   assign nb_rd_addr      = nb_idx_d;

   assign pair_valid      = fire_c ? mask_q : '0;
   assign ref_particle_id = ref_idx_q + PID_W'(ID_BASE);
   assign nb_particle_id  = nb_idx_q + PID_W'(ID_BASE);
   assign busy            = (state_q != ST_IDLE);
   assign done            = (state_q == ST_DONE);

   assign ref_x = ref_rd_x;
   assign ref_y = ref_rd_y;
   assign ref_z = ref_rd_z;
   assign nb_x  = nb_rd_x;
   assign nb_y  = nb_rd_y;
   assign nb_z  = nb_rd_z;

`ifdef RL_PAIR_DISPATCH_STATS_EN
   localparam int unsigned POP_W = cnt_width(NUM_FILTER);

   logic [POP_W-1:0]          pop_c;
   logic [RL_STATS_WIDTH:0]   pair_sum_c;
   logic [RL_STATS_WIDTH-1:0] pair_cnt_q;
   logic [RL_STATS_WIDTH-1:0] stall_cnt_q;

   lane_popcount #(
      .N  (NUM_FILTER),
      .CW (POP_W)
   ) u_lane_popcount (
      .vec_i (pair_valid),
      .cnt_o (pop_c)
   );

   assign pair_sum_c = {1'b0, pair_cnt_q} + (RL_STATS_WIDTH + 1)'(pop_c);

   // Saturating statistics, cleared by an accepted start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pair_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else if (launch_c) begin
         pair_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         pair_cnt_q <= pair_sum_c[RL_STATS_WIDTH] ? '1 : pair_sum_c[RL_STATS_WIDTH-1:0];
         if ((state_q == ST_STREAM) && stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + RL_STATS_WIDTH'(1);
         end
      end
   end

   assign pair_count   = pair_cnt_q;
   assign stall_cycles = stall_cnt_q;
`else
   logic unused_launch;
   assign unused_launch = launch_c;
`endif

endmodule
